stg4ma: RTL and testbench

STG4MA -- requirements
Module: stg4ma

---
 rtl/stg4ma_pkg.sv | 42 ++++
 rtl/stg4ma.sv | 130 +++++++++++++
 tb/tb_stg4ma.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/stg4ma_pkg.sv
// Memory-access stage shared definitions: field widths, opcodes, timeout,
// FSM state encoding and the writeback payload struct.
package stg4ma_pkg;

    localparam int unsigned SIZE_ADDR   = 16;
    localparam int unsigned SIZE_DATA   = 16;
    localparam int unsigned SIZE_OPC    = 6;
    localparam int unsigned SIZE_TGT_GP = 5;
    localparam int unsigned SIZE_TGT_SR = 2;
    localparam int unsigned HBIT_ADDR   = SIZE_ADDR - 1;
    localparam int unsigned SIZE_MA_CNT = 8;

    localparam logic [SIZE_OPC-1:0] OPC_NOP   = 6'h00;
    localparam logic [SIZE_OPC-1:0] OPC_R_ADD = 6'h01;
    localparam logic [SIZE_OPC-1:0] OPC_R_LD  = 6'h10;
    localparam logic [SIZE_OPC-1:0] OPC_R_ST  = 6'h11;

    localparam logic [SIZE_MA_CNT-1:0] MA_TIMEOUT = 8'd255;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } ma_state_t;

    // Instruction fields handed to writeback
    typedef struct packed {
        logic [SIZE_ADDR-1:0]   pc;
        logic [SIZE_DATA-1:0]   instr;
        logic [SIZE_OPC-1:0]    opc;
        logic [SIZE_TGT_GP-1:0] tgt_gp;
        logic [SIZE_TGT_SR-1:0] tgt_sr;
        logic [SIZE_DATA-1:0]   result;
    } wb_fields_t;

    // NOP opcode is all-zero, so the bubble is simply all fields zero
    localparam wb_fields_t WB_BUBBLE = '0;

    function automatic logic is_mem_op(input logic [SIZE_OPC-1:0] opc);
        return (opc == OPC_R_LD) || (opc == OPC_R_ST);
    endfunction

endpackage

// File: rtl/stg4ma.sv
// Memory-access pipeline stage. Non-memory instructions pass through with one
// cycle of latency. LD/ST issue a level request to memory, stall upstream until
// ack or timeout, and emit bubbles meanwhile.
// Ports:
//   iw_clk, iw_rst         clock (rising), async active-high reset
//   iw_pc..iw_st_data      instruction fields, ALU result / EA, store data
//   ow_pc..ow_result       registered fields to writeback
//   ow_mem_req/we/addr/wdata  registered memory request
//   iw_mem_ack, iw_mem_rdata  memory completion and load data
//   ow_stall               combinational upstream hold
//   ow_mem_err             one-cycle pulse on request timeout
module stg4ma
    import stg4ma_pkg::*;
(
    input  logic                   iw_clk,
    input  logic                   iw_rst,
    input  logic [SIZE_ADDR-1:0]   iw_pc,
    input  logic [SIZE_DATA-1:0]   iw_instr,
    input  logic [SIZE_OPC-1:0]    iw_opc,
    input  logic [SIZE_TGT_GP-1:0] iw_tgt_gp,
    input  logic [SIZE_TGT_SR-1:0] iw_tgt_sr,
    input  logic [SIZE_DATA-1:0]   iw_result,
    input  logic [SIZE_DATA-1:0]   iw_st_data,
    output logic [SIZE_ADDR-1:0]   ow_pc,
    output logic [SIZE_DATA-1:0]   ow_instr,
    output logic [SIZE_OPC-1:0]    ow_opc,
    output logic [SIZE_TGT_GP-1:0] ow_tgt_gp,
    output logic [SIZE_TGT_SR-1:0] ow_tgt_sr,
    output logic [SIZE_DATA-1:0]   ow_result,
    output logic                   ow_mem_req,
    output logic                   ow_mem_we,
    output logic [SIZE_ADDR-1:0]   ow_mem_addr,
    output logic [SIZE_DATA-1:0]   ow_mem_wdata,
    input  logic                   iw_mem_ack,
    input  logic [SIZE_DATA-1:0]   iw_mem_rdata,
    output logic                   ow_stall,
    output logic                   ow_mem_err
);

    ma_state_t              state_q, state_nxt;
    logic [SIZE_MA_CNT-1:0] cnt_q, cnt_nxt;
    wb_fields_t             wb_q, wb_nxt, in_fields;
    logic                   req_nxt, we_nxt, err_nxt, stall_c;
    logic [SIZE_ADDR-1:0]   addr_nxt;
    logic [SIZE_DATA-1:0]   wdata_nxt;

    assign in_fields = '{pc: iw_pc, instr: iw_instr, opc: iw_opc,
                         tgt_gp: iw_tgt_gp, tgt_sr: iw_tgt_sr, result: iw_result};

    // Next-state, request and writeback latch selection
    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        wb_nxt    = WB_BUBBLE;
        req_nxt   = ow_mem_req;
        we_nxt    = ow_mem_we;
        addr_nxt  = ow_mem_addr;
        wdata_nxt = ow_mem_wdata;
        err_nxt   = 1'b0;
        stall_c   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (is_mem_op(iw_opc)) begin
                    stall_c   = 1'b1;
                    state_nxt = ST_REQ;
                    cnt_nxt   = '0;
                    req_nxt   = 1'b1;
                    we_nxt    = (iw_opc == OPC_R_ST);
                    addr_nxt  = iw_result[HBIT_ADDR:0];
                    wdata_nxt = iw_st_data;
                end else begin
                    wb_nxt = in_fields;
                end
            end
            ST_REQ: begin
                // Upstream holds iw_* stable while stalled, so they are used directly here
                if (iw_mem_ack) begin
                    wb_nxt        = in_fields;
                    wb_nxt.result = (iw_opc == OPC_R_ST) ? SIZE_DATA'(iw_result[HBIT_ADDR:0])
                                                         : iw_mem_rdata;
                    req_nxt   = 1'b0;
                    cnt_nxt   = '0;
                    state_nxt = ST_IDLE;
                end else if (cnt_q == MA_TIMEOUT) begin
                    // Stall released so upstream drops the failed instruction
                    err_nxt   = 1'b1;
                    req_nxt   = 1'b0;
                    cnt_nxt   = '0;
                    state_nxt = ST_IDLE;
                end else begin
                    stall_c = 1'b1;
                    cnt_nxt = cnt_q + SIZE_MA_CNT'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State, counter, request and writeback registers
    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            wb_q         <= WB_BUBBLE;
            ow_mem_req   <= 1'b0;
            ow_mem_we    <= 1'b0;
            ow_mem_addr  <= '0;
            ow_mem_wdata <= '0;
            ow_mem_err   <= 1'b0;
        end else begin
            state_q      <= state_nxt;
            cnt_q        <= cnt_nxt;
            wb_q         <= wb_nxt;
            ow_mem_req   <= req_nxt;
            ow_mem_we    <= we_nxt;
            ow_mem_addr  <= addr_nxt;
            ow_mem_wdata <= wdata_nxt;
            ow_mem_err   <= err_nxt;
        end
    end

    assign ow_stall  = stall_c & ~iw_rst;
    assign ow_pc     = wb_q.pc;
    assign ow_instr  = wb_q.instr;
    assign ow_opc    = wb_q.opc;
    assign ow_tgt_gp = wb_q.tgt_gp;
    assign ow_tgt_sr = wb_q.tgt_sr;
    assign ow_result = wb_q.result;

endmodule

// File: tb/tb_stg4ma.sv
// Self-checking bench for stg4ma: scoreboard of expected writebacks, per-op
// request/stall/bubble checks, timeout, reset abandonment.
module tb_stg4ma;
    import stg4ma_pkg::*;

    logic                   iw_clk = 1'b0;
    logic                   iw_rst;
    logic [SIZE_ADDR-1:0]   iw_pc;
    logic [SIZE_DATA-1:0]   iw_instr;
    logic [SIZE_OPC-1:0]    iw_opc;
    logic [SIZE_TGT_GP-1:0] iw_tgt_gp;
    logic [SIZE_TGT_SR-1:0] iw_tgt_sr;
    logic [SIZE_DATA-1:0]   iw_result;
    logic [SIZE_DATA-1:0]   iw_st_data;
    logic [SIZE_ADDR-1:0]   ow_pc;
    logic [SIZE_DATA-1:0]   ow_instr;
    logic [SIZE_OPC-1:0]    ow_opc;
    logic [SIZE_TGT_GP-1:0] ow_tgt_gp;
    logic [SIZE_TGT_SR-1:0] ow_tgt_sr;
    logic [SIZE_DATA-1:0]   ow_result;
    logic                   ow_mem_req, ow_mem_we;
    logic [SIZE_ADDR-1:0]   ow_mem_addr;
    logic [SIZE_DATA-1:0]   ow_mem_wdata;
    logic                   iw_mem_ack;
    logic [SIZE_DATA-1:0]   iw_mem_rdata;
    logic                   ow_stall, ow_mem_err;

    int n_checks   = 0;
    int n_errors   = 0;
    int bubbles    = 0;
    int err_pulses = 0;
    wb_fields_t exp_q[$];

    stg4ma dut (
        .iw_clk(iw_clk), .iw_rst(iw_rst),
        .iw_pc(iw_pc), .iw_instr(iw_instr), .iw_opc(iw_opc),
        .iw_tgt_gp(iw_tgt_gp), .iw_tgt_sr(iw_tgt_sr),
        .iw_result(iw_result), .iw_st_data(iw_st_data),
        .ow_pc(ow_pc), .ow_instr(ow_instr), .ow_opc(ow_opc),
        .ow_tgt_gp(ow_tgt_gp), .ow_tgt_sr(ow_tgt_sr), .ow_result(ow_result),
        .ow_mem_req(ow_mem_req), .ow_mem_we(ow_mem_we),
        .ow_mem_addr(ow_mem_addr), .ow_mem_wdata(ow_mem_wdata),
        .iw_mem_ack(iw_mem_ack), .iw_mem_rdata(iw_mem_rdata),
        .ow_stall(ow_stall), .ow_mem_err(ow_mem_err)
    );

    always #5 iw_clk = ~iw_clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic [SIZE_OPC-1:0] opc, input logic [SIZE_ADDR-1:0] pc,
                          input logic [SIZE_DATA-1:0] instr, input logic [SIZE_TGT_GP-1:0] gp,
                          input logic [SIZE_TGT_SR-1:0] sr, input logic [SIZE_DATA-1:0] res,
                          input logic [SIZE_DATA-1:0] st);
        iw_opc = opc; iw_pc = pc; iw_instr = instr; iw_tgt_gp = gp;
        iw_tgt_sr = sr; iw_result = res; iw_st_data = st;
    endtask

    // Writeback monitor: registered outputs settle 2ns after the rising edge
    always @(posedge iw_clk) begin
        wb_fields_t e;
        #2;
        if (!iw_rst) begin
            if (ow_opc == OPC_NOP) begin
                bubbles++;
                chk("bubble_zero", {9'd0, ow_pc, ow_instr, ow_tgt_gp, ow_tgt_sr, ow_result}, 64'd0);
            end else if (exp_q.size() == 0) begin
                chk("unexpected_wb", 64'(ow_opc), 64'(OPC_NOP));
            end else begin
                e = exp_q.pop_front();
                chk("wb_opc",    64'(ow_opc),    64'(e.opc));
                chk("wb_pc",     64'(ow_pc),     64'(e.pc));
                chk("wb_instr",  64'(ow_instr),  64'(e.instr));
                chk("wb_tgt_gp", 64'(ow_tgt_gp), 64'(e.tgt_gp));
                chk("wb_tgt_sr", 64'(ow_tgt_sr), 64'(e.tgt_sr));
                chk("wb_result", 64'(ow_result), 64'(e.result));
            end
            if (ow_mem_err) err_pulses++;
        end
    end

    // Non-memory op (optionally with a stray ack); called and returns at a negedge
    task automatic alu_op(input logic [SIZE_OPC-1:0] opc, input logic [SIZE_ADDR-1:0] pc,
                          input logic [SIZE_DATA-1:0] res, input logic ack);
        wb_fields_t e;
        set_in(opc, pc, 16'hA000 | 16'(pc), 5'(pc), 2'(pc), res, 16'hFFFF);
        iw_mem_ack = ack;
        #1 chk("alu_stall", 64'(ow_stall), 64'd0);
        e = '{pc: pc, instr: 16'hA000 | 16'(pc), opc: opc, tgt_gp: 5'(pc), tgt_sr: 2'(pc), result: res};
        exp_q.push_back(e);
        @(negedge iw_clk);
        chk("alu_req", 64'(ow_mem_req), 64'd0);
        chk("alu_err", 64'(ow_mem_err), 64'd0);
        iw_mem_ack = 1'b0;
    endtask

    // LD/ST with ack in REQ cycle ack_dly (> MA_TIMEOUT means never)
    task automatic mem_op(input logic is_st, input logic [SIZE_ADDR-1:0] pc,
                          input logic [SIZE_ADDR-1:0] addr, input logic [SIZE_DATA-1:0] st,
                          input int ack_dly, input logic [SIZE_DATA-1:0] rdata);
        wb_fields_t e;
        int b0;
        logic [SIZE_OPC-1:0] opc;
        opc = is_st ? OPC_R_ST : OPC_R_LD;
        b0 = bubbles;
        set_in(opc, pc, 16'h5000 | 16'(pc), 5'd7, 2'd1, addr, st);
        iw_mem_ack = 1'b0;
        #1 chk("mem_idle_stall", 64'(ow_stall), 64'd1);
        for (int k = 0; k <= int'(MA_TIMEOUT); k++) begin
            @(negedge iw_clk);
            chk("mem_req",   64'(ow_mem_req),   64'd1);
            chk("mem_we",    64'(ow_mem_we),    64'(is_st));
            chk("mem_addr",  64'(ow_mem_addr),  64'(addr));
            chk("mem_wdata", 64'(ow_mem_wdata), 64'(st));
            if (k == ack_dly) begin
                iw_mem_ack = 1'b1;
                iw_mem_rdata = rdata;
                #1 chk("mem_ack_stall", 64'(ow_stall), 64'd0);
                e = '{pc: pc, instr: 16'h5000 | 16'(pc), opc: opc, tgt_gp: 5'd7, tgt_sr: 2'd1,
                      result: is_st ? 16'(addr) : rdata};
                exp_q.push_back(e);
                @(negedge iw_clk);
                iw_mem_ack = 1'b0;
                chk("mem_done_req", 64'(ow_mem_req), 64'd0);
                chk("mem_done_err", 64'(ow_mem_err), 64'd0);
                chk("mem_bubbles",  64'(bubbles - b0), 64'(ack_dly + 1));
                return;
            end
            #1 chk("mem_wait_stall", 64'(ow_stall), (k == int'(MA_TIMEOUT)) ? 64'd0 : 64'd1);
        end
        @(negedge iw_clk);
        chk("to_req",     64'(ow_mem_req), 64'd0);
        chk("to_err",     64'(ow_mem_err), 64'd1);
        chk("to_bubbles", 64'(bubbles - b0), 64'(int'(MA_TIMEOUT) + 2));
    endtask

    initial begin
        iw_rst = 1'b1;
        iw_mem_ack = 1'b0;
        iw_mem_rdata = '0;
        set_in(OPC_NOP, '0, '0, '0, '0, '0, '0);
        #1;
        chk("rst_wb", {9'd0, ow_pc, ow_instr, ow_tgt_gp, ow_tgt_sr, ow_result}, 64'd0);
        chk("rst_opc", 64'(ow_opc), 64'd0);
        chk("rst_mem", {ow_mem_req, ow_mem_we, ow_mem_err, ow_mem_addr, ow_mem_wdata}, 64'd0);
        set_in(OPC_R_LD, 16'h1, 16'h2, 5'd3, 2'd1, 16'h40, 16'h0);
        #1 chk("rst_stall", 64'(ow_stall), 64'd0);
        set_in(OPC_NOP, '0, '0, '0, '0, '0, '0);
        @(negedge iw_clk); @(negedge iw_clk);
        iw_rst = 1'b0;

        alu_op(OPC_R_ADD, 16'h0010, 16'h1234, 1'b0);
        for (int i = 0; i < 3; i++)
            alu_op(6'($urandom_range(1, 15)), 16'($urandom), 16'($urandom), 1'b0);

        mem_op(1'b0, 16'h0020, 16'h0040, 16'h0000, 3, 16'hBEEF);
        mem_op(1'b1, 16'h0024, 16'h0080, 16'h0055, 0, 16'h1111);
        // Back-to-back memory ops
        mem_op(1'b0, 16'h0028, 16'h0100, 16'h0000, 1, 16'hCAFE);
        mem_op(1'b1, 16'h002C, 16'h0104, 16'hA5A5, 2, 16'h0000);
        alu_op(OPC_R_ADD, 16'h0030, 16'h0777, 1'b0);

        // Timeout, then the pulse must not repeat and ADD passes through
        mem_op(1'b0, 16'h0034, 16'h0200, 16'h0000, 1000, 16'h0000);
        alu_op(OPC_R_ADD, 16'h0038, 16'h4321, 1'b0);
        chk("err_pulses_to", 64'(err_pulses), 64'd1);

        // Ack arriving on the timeout cycle completes normally
        mem_op(1'b0, 16'h003C, 16'h0300, 16'h0000, int'(MA_TIMEOUT), 16'h7E57);
        chk("err_pulses_race", 64'(err_pulses), 64'd1);

        // Ack seen in IDLE is ignored
        alu_op(OPC_R_ADD, 16'h0040, 16'h0A0A, 1'b1);

        // Reset in the middle of a request, then a late ack
        set_in(OPC_R_LD, 16'h0044, 16'h5044, 5'd7, 2'd1, 16'h0400, 16'h0);
        repeat (3) @(negedge iw_clk);
        chk("prerst_req", 64'(ow_mem_req), 64'd1);
        #1 iw_rst = 1'b1;
        #1;
        chk("midrst_mem", {ow_mem_req, ow_mem_we, ow_mem_err, ow_mem_addr, ow_mem_wdata}, 64'd0);
        chk("midrst_wb", {3'd0, ow_opc, ow_pc, ow_instr, ow_tgt_gp, ow_tgt_sr, ow_result}, 64'd0);
        chk("midrst_stall", 64'(ow_stall), 64'd0);
        set_in(OPC_NOP, '0, '0, '0, '0, '0, '0);
        @(negedge iw_clk);
        iw_rst = 1'b0;
        iw_mem_ack = 1'b1;
        iw_mem_rdata = 16'hDEAD;
        repeat (2) begin
            @(negedge iw_clk);
            chk("late_ack_req", 64'(ow_mem_req), 64'd0);
            chk("late_ack_opc", 64'(ow_opc), 64'(OPC_NOP));
        end
        iw_mem_ack = 1'b0;
        repeat (2) @(negedge iw_clk);
        chk("err_pulses_end", 64'(err_pulses), 64'd1);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
